// File: rtl/out_ports.sv
// Output-port unit: three latched ports with update strobes plus a streaming FIFO port.
// Define OUT_IRQ_EN to add an irq pulse when a pop drains the FIFO.
module out_ports #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_out,
  input  logic [1:0]         port,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   p0_out,
  output logic [WIDTH-1:0]   p1_out,
  output logic [WIDTH-1:0]   p2_out,
  output logic [2:0]         stb,
  output logic [WIDTH-1:0]   p3_data,
  output logic               p3_valid,
  input  logic               p3_ready,
  output logic               out_full,
  output logic               out_ovf,
`ifdef OUT_IRQ_EN
  output logic               irq,
`endif
  output logic [FIFO_AW:0]   out_count
);

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               wr3;
  logic               push;
  logic               pop;

  // Full is judged on the pre-edge count, so a pop in the same cycle does not make room.
  assign wr3       = we_out && (port == 2'd3);
  assign push      = wr3 && (count != FULL_CNT);
  assign pop       = (count != '0) && p3_ready;

  assign p3_valid  = (count != '0);
  assign out_full  = (count == FULL_CNT);
  assign out_count = count;
  assign p3_data   = mem[rd_ptr];

  // Storage has no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_out  <= '0;
      p1_out  <= '0;
      p2_out  <= '0;
      stb     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_ovf <= 1'b0;
    end else begin
      stb <= '0;
      if (we_out) begin
        case (port)
          2'd0: begin p0_out <= wdata; stb <= 3'b001; end
          2'd1: begin p1_out <= wdata; stb <= 3'b010; end
          2'd2: begin p2_out <= wdata; stb <= 3'b100; end
          default: ;
        endcase
      end
      if (wr3 && !push) out_ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef OUT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= pop && !push && (count == (FIFO_AW+1)'(1));
  end
`endif

endmodule

// File: tb/tb_out_ports.sv
// Self-checking bench for out_ports: queue-based reference model with randomized stimulus.
module tb_out_ports;

  logic        clk;
  logic        reset;
  logic        we_out;
  logic [1:0]  port;
  logic [15:0] wdata;
  logic [15:0] p0_out, p1_out, p2_out, p3_data;
  logic [2:0]  stb;
  logic        p3_valid, p3_ready, out_full, out_ovf;
  logic [2:0]  out_count;
  logic        irq_sig;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q[$];
  logic [15:0] popped[$];
  logic [15:0] m_p [3];
  logic [2:0]  m_stb;
  logic        m_ovf;
  logic        m_irq;

  out_ports dut (
    .clk(clk), .reset(reset), .we_out(we_out), .port(port), .wdata(wdata),
    .p0_out(p0_out), .p1_out(p1_out), .p2_out(p2_out), .stb(stb),
    .p3_data(p3_data), .p3_valid(p3_valid), .p3_ready(p3_ready),
    .out_full(out_full), .out_ovf(out_ovf),
`ifdef OUT_IRQ_EN
    .irq(irq_sig),
`endif
    .out_count(out_count)
  );

`ifndef OUT_IRQ_EN
  assign irq_sig = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] exp_vec();
    logic [15:0] head;
    head = (q.size() != 0) ? q[0] : 16'h0;
    return {m_p[0], m_p[1], m_p[2], m_stb, q.size() != 0, q.size() == 4, m_ovf,
            3'(q.size()), head, m_irq};
  endfunction

  function automatic logic [73:0] obs_vec();
    return {p0_out, p1_out, p2_out, stb, p3_valid, out_full, out_ovf, out_count,
            p3_valid ? p3_data : 16'h0, irq_sig};
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) m_p[i] = 16'h0;
    m_stb = 3'b000;
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endtask

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic cycle(input logic we, input logic [1:0] pt, input logic [15:0] d, input logic rdy);
    int  sz;
    bit  do_pop, do_push;
    we_out = we; port = pt; wdata = d; p3_ready = rdy;
    sz      = q.size();
    do_pop  = (sz != 0) && rdy;
    do_push = we && (pt == 2'd3) && (sz < 4);
    if (rdy && p3_valid) popped.push_back(p3_data);
    @(posedge clk); #1;
    if (we && pt == 2'd3 && sz == 4) m_ovf = 1'b1;
    m_stb = 3'b000;
    if (we && pt != 2'd3) begin
      m_p[pt] = d;
      m_stb   = 3'(1 << pt);
    end
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
`ifdef OUT_IRQ_EN
    m_irq = do_pop && !do_push && (sz == 1);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; we_out = 1'b0; port = 2'd0; wdata = 16'h0; p3_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL reset_state got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    reset = 1'b0;
  endtask

  task automatic test_ports();
    cycle(1'b1, 2'd1, 16'h1234, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || stb !== 3'b010 || p1_out !== 16'h1234) begin
      $display("FAIL p1_write got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    cycle(1'b0, 2'd1, 16'h0, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || stb !== 3'b000) begin
      $display("FAIL p1_strobe_once got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), 16'($urandom), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL ports_random[%0d] got %h exp %h", i, obs_vec(), exp_vec());
        n_fail++;
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] words [5] = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'd3, words[i], 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL fill[%0d] got %h exp %h", i, obs_vec(), exp_vec());
        n_fail++;
      end
    end
    n_checks++;
    if (out_count !== 3'd4 || out_full !== 1'b1 || out_ovf !== 1'b1 || p3_data !== 16'hA) begin
      $display("FAIL overflow_drop count=%0d full=%b ovf=%b data=%h exp 4 1 1 000a",
               out_count, out_full, out_ovf, p3_data);
      n_fail++;
    end
  endtask

  task automatic test_drain();
    popped.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'd0, 16'h0, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL drain[%0d] got %h exp %h", i, obs_vec(), exp_vec());
        n_fail++;
      end
    end
    n_checks++;
    if (popped.size() != 4 || popped[0] !== 16'hA || popped[1] !== 16'hB ||
        popped[2] !== 16'hC || popped[3] !== 16'hD) begin
      $display("FAIL drain_order got %p exp A B C D", popped);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd3, 16'(16'h100 + i), 1'b0);
    cycle(1'b1, 2'd3, 16'h1FF, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec() || out_count !== 3'd3) begin
      $display("FAIL full_push_pop got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    cycle(1'b0, 2'd0, 16'h0, 1'b1);
    cycle(1'b1, 2'd3, 16'h2AA, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec() || out_count !== 3'd2) begin
      $display("FAIL mid_push_pop got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
  endtask

  task automatic test_wrap_random();
    int nxt;
    for (int i = 0; i < 8 && q.size() != 0; i++) cycle(1'b0, 2'd0, 16'h0, 1'b1);
    popped.delete();
    nxt = 1;
    for (int i = 0; i < 300 && popped.size() < 10; i++) begin
      if (nxt <= 10 && q.size() < 4 && $urandom_range(0, 1) == 1) begin
        cycle(1'b1, 2'd3, 16'(nxt), 1'($urandom_range(0, 1)));
        nxt++;
      end else begin
        cycle(1'b0, 2'd0, 16'h0, 1'($urandom_range(0, 1)));
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL wrap_cycle[%0d] got %h exp %h", i, obs_vec(), exp_vec());
        n_fail++;
      end
    end
    n_checks++;
    if (popped.size() != 10) begin
      $display("FAIL wrap_count got %0d exp 10", popped.size());
      n_fail++;
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (popped[i] !== 16'(i + 1)) begin
          $display("FAIL wrap_seq[%0d] got %0d exp %0d", i, popped[i], i + 1);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, 16'(16'h30 + i), 1'b0);
    cycle(1'b1, 2'd0, 16'h5A5A, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || out_count !== 3'd3) begin
      $display("FAIL pre_reset got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    we_out = 1'b0; p3_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec() || out_count !== 3'd0 || p3_valid !== 1'b0) begin
      $display("FAIL async_reset got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 2'd3, 16'hBEEF, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || p3_data !== 16'hBEEF || p3_valid !== 1'b1) begin
      $display("FAIL post_reset_push got %h exp %h", obs_vec(), exp_vec());
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_ports();
    test_fill_overflow();
    test_drain();
    test_simultaneous();
    test_wrap_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
